// File: rtl/hyper_titan_nocs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hyper_titan_nocs_pkg
//  Description : Shared peripheral-link NoC definitions. Provides the
//                AXI-Lite master-port request/response bundles, the bus
//                widths, and the AXI response codes used by link slaves.
//  Contents    : PL_MP_DW / PL_MP_AW      - data / address width
//                PL_RESP_OKAY / _SLVERR  - B/R response encodings
//                pl_m_axil_req_t         - master -> slave channel fields
//                pl_m_axil_resp_t        - slave -> master channel fields
//  Revision    : 1.0 - initial release
// ============================================================================
package hyper_titan_nocs_pkg;

   localparam int PL_MP_DW = 32;
   localparam int PL_MP_AW = 32;

   localparam logic [1:0] PL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] PL_RESP_SLVERR = 2'b10;

   // Request bundle: everything the xbar master port drives toward a slave.
   typedef struct packed {
      logic [PL_MP_AW-1:0]   aw_addr;
      logic                  aw_valid;
      logic [PL_MP_DW-1:0]   w_data;
      logic [PL_MP_DW/8-1:0] w_strb;
      logic                  w_valid;
      logic                  b_ready;
      logic [PL_MP_AW-1:0]   ar_addr;
      logic                  ar_valid;
      logic                  r_ready;
   } pl_m_axil_req_t;

   // Response bundle: everything a slave drives back to the xbar.
   typedef struct packed {
      logic                  aw_ready;
      logic                  w_ready;
      logic [1:0]            b_resp;
      logic                  b_valid;
      logic                  ar_ready;
      logic [PL_MP_DW-1:0]   r_data;
      logic [1:0]            r_resp;
      logic                  r_valid;
   } pl_m_axil_resp_t;

endpackage : hyper_titan_nocs_pkg
`default_nettype wire

// File: rtl/pl_axil_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : pl_axil_regbank
//  Description : AXI-Lite slave exposing NUM_REGS 32-bit registers at
//                BASE_ADDR. Registers flagged in RO_MASK are read-only and
//                return live hardware values from ro_data_i. Writes commit
//                one cycle after both AW and W have been captured; reads
//                return registered data one cycle after the AR handshake.
//  Ports       : clk_i       - clock, all state on rising edge
//                rst_i       - synchronous active-high reset
//                req_i       - AXI-Lite request bundle from the xbar
//                resp_o      - AXI-Lite response bundle to the xbar
//                reg_o       - writable register contents, reg i at [32i+:32]
//                ro_data_i   - read-only register sources, reg i at [32i+:32]
//                wr_pulse_o  - one-cycle pulse per register on write commit
//  Revision    : 1.0 - initial release
// ============================================================================
module pl_axil_regbank
   import hyper_titan_nocs_pkg::*;
#(
   parameter int                  NUM_REGS  = 16,
   parameter logic [PL_MP_AW-1:0] BASE_ADDR = 32'h0,
   parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  pl_m_axil_req_t               req_i,
   output pl_m_axil_resp_t              resp_o,
   output logic [NUM_REGS*PL_MP_DW-1:0] reg_o,
   input  logic [NUM_REGS*PL_MP_DW-1:0] ro_data_i,
   output logic [NUM_REGS-1:0]          wr_pulse_o
);

   localparam int c_NB = PL_MP_DW / 8;

   // -------------------------------------------------------------------------
   // Address decode shared by both paths. Returns a one-hot register select;
   // an all-zero result means the address falls outside the bank. The two
   // low address bits are ignored because the shift drops them.
   // -------------------------------------------------------------------------
   function automatic logic [NUM_REGS-1:0] f_decode(input logic [PL_MP_AW-1:0] addr);
      logic [PL_MP_AW-1:0] off;
      logic [NUM_REGS-1:0] sel;
      off = addr - BASE_ADDR;
      sel = '0;
      if ((addr >= BASE_ADDR) && (off < PL_MP_AW'(NUM_REGS * 4))) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if ((off >> 2) == PL_MP_AW'(i)) begin
               sel[i] = 1'b1;
            end
         end
      end
      return sel;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic                  r_aw_held;
   logic [PL_MP_AW-1:0]   r_aw_addr;
   logic                  r_w_held;
   logic [PL_MP_DW-1:0]   r_w_data;
   logic [c_NB-1:0]       r_w_strb;
   logic                  r_b_valid;
   logic [1:0]            r_b_resp;
   logic [NUM_REGS-1:0]   r_wr_pulse;
   logic [PL_MP_DW-1:0]   r_regs [NUM_REGS];

   logic                  r_r_valid;
   logic [PL_MP_DW-1:0]   r_r_data;
   logic [1:0]            r_r_resp;

   // -------------------------------------------------------------------------
   // Combinational handshake / decode
   // -------------------------------------------------------------------------
   logic                  w_aw_ready;
   logic                  w_w_ready;
   logic                  w_ar_ready;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic                  w_commit;
   logic [NUM_REGS-1:0]   w_wr_sel;
   logic [NUM_REGS-1:0]   w_wr_ok_sel;
   logic                  w_wr_ok;
   logic [NUM_REGS-1:0]   w_rd_sel;
   logic [PL_MP_DW-1:0]   w_rd_data;

   // A pending B response blocks both write channels so the held
   // address/data can never be overwritten before the response drains.
   assign w_aw_ready = ~r_aw_held & ~r_b_valid;
   assign w_w_ready  = ~r_w_held  & ~r_b_valid;
   assign w_ar_ready = ~r_r_valid;

   assign w_aw_hs    = req_i.aw_valid & w_aw_ready;
   assign w_w_hs     = req_i.w_valid  & w_w_ready;
   assign w_ar_hs    = req_i.ar_valid & w_ar_ready;

   // Commit only from the held copies: this fixes the AW/W-to-B latency at
   // two cycles regardless of which channel arrived last.
   assign w_commit    = r_aw_held & r_w_held & ~r_b_valid;

   assign w_wr_sel    = f_decode(r_aw_addr);
   assign w_wr_ok_sel = w_wr_sel & ~RO_MASK;
   assign w_wr_ok     = |w_wr_ok_sel;

   assign w_rd_sel    = f_decode(req_i.ar_addr);

   // Read source mux: read-only registers return the live hardware input,
   // writable ones the stored value. Sampled before any same-edge write
   // lands, so a colliding read observes the pre-write contents.
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_rd_sel[i]) begin
            w_rd_data = RO_MASK[i] ? ro_data_i[i*PL_MP_DW +: PL_MP_DW] : r_regs[i];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Write channel capture and B response
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_aw_held  <= 1'b0;
         r_aw_addr  <= '0;
         r_w_held   <= 1'b0;
         r_w_data   <= '0;
         r_w_strb   <= '0;
         r_b_valid  <= 1'b0;
         r_b_resp   <= PL_RESP_OKAY;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;

         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_addr <= req_i.aw_addr;
         end

         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_w_data <= req_i.w_data;
            r_w_strb <= req_i.w_strb;
         end

         if (w_commit) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_b_valid  <= 1'b1;
            r_b_resp   <= w_wr_ok ? PL_RESP_OKAY : PL_RESP_SLVERR;
            // Pulses even for an all-zero strobe; target software may use
            // the write event itself as a trigger.
            r_wr_pulse <= w_wr_ok_sel;
         end else if (r_b_valid && req_i.b_ready) begin
            r_b_valid  <= 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Register storage with byte-strobe merge
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_ok_sel[i]) begin
               for (int k = 0; k < c_NB; k++) begin
                  if (r_w_strb[k]) begin
                     r_regs[i][8*k +: 8] <= r_w_data[8*k +: 8];
                  end
               end
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read path: single outstanding read, data registered at the handshake
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_r_valid <= 1'b0;
         r_r_data  <= '0;
         r_r_resp  <= PL_RESP_OKAY;
      end else if (w_ar_hs) begin
         r_r_valid <= 1'b1;
         r_r_data  <= w_rd_data;
         r_r_resp  <= (|w_rd_sel) ? PL_RESP_OKAY : PL_RESP_SLVERR;
      end else if (r_r_valid && req_i.r_ready) begin
         r_r_valid <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      resp_o          = '0;
      resp_o.aw_ready = w_aw_ready;
      resp_o.w_ready  = w_w_ready;
      resp_o.b_valid  = r_b_valid;
      resp_o.b_resp   = r_b_resp;
      resp_o.ar_ready = w_ar_ready;
      resp_o.r_valid  = r_r_valid;
      resp_o.r_data   = r_r_data;
      resp_o.r_resp   = r_r_resp;
   end

   assign wr_pulse_o = r_wr_pulse;

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
         assign reg_o[g*PL_MP_DW +: PL_MP_DW] = r_regs[g];
      end
   endgenerate

endmodule : pl_axil_regbank
`default_nettype wire

// File: tb/tb_pl_axil_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pl_axil_regbank
//  Description : Self-checking bench for pl_axil_regbank. A small array
//                model of the register bank predicts every response, read
//                value and write pulse; directed scenarios cover the timing
//                and corner cases, followed by a randomized mix.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pl_axil_regbank;
   import hyper_titan_nocs_pkg::*;

   localparam int          NUM  = 8;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [7:0]  RO   = 8'b0100_1000;

   logic                clk = 1'b0;
   logic                rst;
   pl_m_axil_req_t      req;
   pl_m_axil_resp_t     resp;
   logic [NUM*32-1:0]   reg_o;
   logic [NUM*32-1:0]   ro_data;
   logic [NUM-1:0]      wr_pulse;

   int                  n_vec = 0;
   int                  n_err = 0;
   logic [31:0]         m_regs [NUM];
   logic [NUM-1:0]      ro_mask_v = RO;

   always #5 clk = ~clk;

   pl_axil_regbank #(
      .NUM_REGS  (NUM),
      .BASE_ADDR (BASE),
      .RO_MASK   (RO)
   ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .resp_o     (resp),
      .reg_o      (reg_o),
      .ro_data_i  (ro_data),
      .wr_pulse_o (wr_pulse)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int m_index(input logic [31:0] a);
      logic [31:0] off;
      if (a < BASE) return -1;
      off = a - BASE;
      if (off >= 32'(NUM * 4)) return -1;
      return int'(off / 4);
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r, output logic [NUM-1:0] p);
      int i;
      i = m_index(a);
      p = '0;
      r = PL_RESP_SLVERR;
      if (i >= 0) begin
         if (!ro_mask_v[i]) begin
            r    = PL_RESP_OKAY;
            p[i] = 1'b1;
            for (int k = 0; k < 4; k++)
               if (s[k]) m_regs[i][8*k +: 8] = d[8*k +: 8];
         end
      end
   endtask

   task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      int i;
      i = m_index(a);
      d = 32'h0;
      r = PL_RESP_SLVERR;
      if (i >= 0) begin
         r = PL_RESP_OKAY;
         d = ro_mask_v[i] ? ro_data[i*32 +: 32] : m_regs[i];
      end
   endtask

   function automatic logic [NUM*32-1:0] m_flat();
      logic [NUM*32-1:0] v;
      for (int i = 0; i < NUM; i++) v[i*32 +: 32] = m_regs[i];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      for (int i = 0; i < NUM; i++) m_regs[i] = 32'h0;
      @(negedge clk);
      n_vec++;
      if ({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid} !== 5'b11100) begin
         n_err++;
         $display("FAIL reset_hs: got %b expected 11100",
                  {resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid});
      end
      n_vec++;
      if (reg_o !== '0 || wr_pulse !== '0) begin
         n_err++;
         $display("FAIL reset_regs: got %h/%b expected 0/0", reg_o, wr_pulse);
      end
      step();
   endtask

   // mode 0: AW and W together; 1: AW then W after gap; 2: W then AW after gap
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int mode, input int gap, input string tag);
      logic [1:0]        er;
      logic [NUM-1:0]    ep;
      logic [NUM*32-1:0] ev;
      int                ch;
      m_write(a, d, s, er, ep);
      ev = m_flat();
      if (mode == 0) begin
         req.aw_addr = a; req.aw_valid = 1'b1;
         req.w_data = d;  req.w_strb = s; req.w_valid = 1'b1;
         @(negedge clk);
         n_vec++;
         if ({resp.aw_ready, resp.w_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL %s aw_w_ready: got %b expected 11", tag, {resp.aw_ready, resp.w_ready});
         end
         step();
         req.aw_valid = 1'b0; req.w_valid = 1'b0;
      end else begin
         for (int ph = 0; ph < 2; ph++) begin
            ch = (mode == 1) ? ph : 1 - ph;
            if (ch == 0) begin req.aw_addr = a; req.aw_valid = 1'b1; end
            else begin req.w_data = d; req.w_strb = s; req.w_valid = 1'b1; end
            @(negedge clk);
            n_vec++;
            if ((ch == 0 ? resp.aw_ready : resp.w_ready) !== 1'b1) begin
               n_err++;
               $display("FAIL %s ready_ch%0d: got 0 expected 1", tag, ch);
            end
            step();
            req.aw_valid = 1'b0; req.w_valid = 1'b0;
            if (ph == 0) repeat (gap) step();
         end
      end
      @(negedge clk);
      n_vec++;
      if (resp.b_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s b_early: got %b expected 0", tag, resp.b_valid);
      end
      step();
      @(negedge clk);
      n_vec++;
      if ({resp.b_valid, resp.b_resp, wr_pulse} !== {1'b1, er, ep}) begin
         n_err++;
         $display("FAIL %s b_resp_pulse: got %b/%b/%b expected 1/%b/%b",
                  tag, resp.b_valid, resp.b_resp, wr_pulse, er, ep);
      end
      step();
      @(negedge clk);
      n_vec++;
      if ({resp.b_valid, wr_pulse} !== {1'b0, {NUM{1'b0}}}) begin
         n_err++;
         $display("FAIL %s b_clear: got %b/%b expected 0/0", tag, resp.b_valid, wr_pulse);
      end
      n_vec++;
      if (reg_o !== ev) begin
         n_err++;
         $display("FAIL %s regs: got %h expected %h", tag, reg_o, ev);
      end
      step();
   endtask

   task automatic do_read(input logic [31:0] a, input string tag);
      logic [31:0] ed;
      logic [1:0]  er;
      m_read(a, ed, er);
      req.ar_addr = a; req.ar_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (resp.ar_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s ar_ready: got %b expected 1", tag, resp.ar_ready);
      end
      step();
      req.ar_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({resp.r_valid, resp.r_resp, resp.r_data} !== {1'b1, er, ed}) begin
         n_err++;
         $display("FAIL %s rdata: got %b/%b/%h expected 1/%b/%h",
                  tag, resp.r_valid, resp.r_resp, resp.r_data, er, ed);
      end
      step();
      @(negedge clk);
      n_vec++;
      if (resp.r_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s r_clear: got %b expected 0", tag, resp.r_valid);
      end
      step();
   endtask

   task automatic test_write_timing();
      // AW in cycle 0, W in cycle 3: B and the pulse land in cycle 5
      do_write(BASE + 8, 32'hDEADBEEF, 4'hF, 1, 2, "timing");
      n_vec++;
      if (reg_o[2*32 +: 32] !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL timing_reg2: got %h expected deadbeef", reg_o[2*32 +: 32]);
      end
      do_read(BASE + 8, "timing_rd");
   endtask

   task automatic test_strobe();
      do_write(BASE + 4, 32'h11223344, 4'hF, 0, 0, "strb_full");
      do_write(BASE + 4, 32'hAABBCCDD, 4'b0101, 2, 1, "strb_part");
      n_vec++;
      if (reg_o[1*32 +: 32] !== 32'h11BB33DD) begin
         n_err++;
         $display("FAIL strb_merge: got %h expected 11bb33dd", reg_o[1*32 +: 32]);
      end
      do_write(BASE + 4, 32'hFFFFFFFF, 4'h0, 0, 0, "strb_zero");
   endtask

   task automatic test_read_only();
      do_write(BASE + 12, 32'h12345678, 4'hF, 0, 0, "ro_wr");
      do_read(BASE + 12, "ro_rd");
      do_read(BASE + 24, "ro6_rd");
   endtask

   task automatic test_out_of_range();
      do_read(BASE + 4 * NUM, "oor_rd");
      do_write(BASE + 4 * NUM, 32'hA5A5A5A5, 4'hF, 0, 0, "oor_wr");
      do_read(BASE - 4, "below_rd");
   endtask

   task automatic test_read_during_commit();
      logic [31:0]    old_d;
      logic [1:0]     old_r;
      logic [1:0]     er;
      logic [NUM-1:0] ep;
      do_write(BASE + 20, 32'h5555AAAA, 4'hF, 0, 0, "rdc_pre");
      m_read(BASE + 20, old_d, old_r);
      m_write(BASE + 20, 32'h0BADF00D, 4'hF, er, ep);
      req.aw_addr = BASE + 20; req.aw_valid = 1'b1;
      req.w_data = 32'h0BADF00D; req.w_strb = 4'hF; req.w_valid = 1'b1;
      step();
      req.aw_valid = 1'b0; req.w_valid = 1'b0;
      req.ar_addr = BASE + 20; req.ar_valid = 1'b1;   // lands in the commit cycle
      step();
      req.ar_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({resp.r_valid, resp.r_data, resp.b_valid, resp.b_resp, wr_pulse} !==
          {1'b1, old_d, 1'b1, er, ep}) begin
         n_err++;
         $display("FAIL rdc_collide: got %b/%h/%b/%b/%b expected 1/%h/1/%b/%b",
                  resp.r_valid, resp.r_data, resp.b_valid, resp.b_resp, wr_pulse,
                  old_d, er, ep);
      end
      step();
      @(negedge clk);
      n_vec++;
      if (reg_o !== m_flat()) begin
         n_err++;
         $display("FAIL rdc_regs: got %h expected %h", reg_o, m_flat());
      end
      step();
   endtask

   task automatic test_b_stall();
      logic [1:0]     er;
      logic [NUM-1:0] ep;
      logic [31:0]    ed;
      logic [1:0]     edr;
      m_write(BASE, 32'hC0DE1234, 4'hF, er, ep);
      req.b_ready = 1'b0;
      req.aw_addr = BASE; req.aw_valid = 1'b1;
      req.w_data = 32'hC0DE1234; req.w_strb = 4'hF; req.w_valid = 1'b1;
      step();
      req.aw_valid = 1'b0; req.w_valid = 1'b0;
      step();
      ed = 32'h0; edr = 2'b00;
      for (int j = 0; j < 10; j++) begin
         if (j % 2 == 0) begin
            m_read(BASE, ed, edr);
            req.ar_addr = BASE; req.ar_valid = 1'b1;
         end
         @(negedge clk);
         n_vec++;
         if ({resp.aw_ready, resp.w_ready, resp.b_valid, resp.b_resp} !== {3'b001, er}) begin
            n_err++;
            $display("FAIL stall_b_%0d: got %b%b%b/%b expected 001/%b",
                     j, resp.aw_ready, resp.w_ready, resp.b_valid, resp.b_resp, er);
         end
         n_vec++;
         if (wr_pulse !== ((j == 0) ? ep : {NUM{1'b0}})) begin
            n_err++;
            $display("FAIL stall_pulse_%0d: got %b expected %b", j, wr_pulse,
                     (j == 0) ? ep : {NUM{1'b0}});
         end
         n_vec++;
         if (j % 2 == 0) begin
            if (resp.ar_ready !== 1'b1) begin
               n_err++;
               $display("FAIL stall_ar_%0d: got %b expected 1", j, resp.ar_ready);
            end
         end else begin
            if ({resp.r_valid, resp.r_resp, resp.r_data} !== {1'b1, edr, ed}) begin
               n_err++;
               $display("FAIL stall_rd_%0d: got %b/%b/%h expected 1/%b/%h",
                        j, resp.r_valid, resp.r_resp, resp.r_data, edr, ed);
            end
         end
         step();
         req.ar_valid = 1'b0;
      end
      req.b_ready = 1'b1;
      step();
      @(negedge clk);
      n_vec++;
      if ({resp.b_valid, resp.aw_ready, resp.w_ready} !== 3'b011) begin
         n_err++;
         $display("FAIL stall_release: got %b expected 011",
                  {resp.b_valid, resp.aw_ready, resp.w_ready});
      end
      step();
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 40; n++) begin
         a = BASE - 8 + 32'($urandom_range(0, NUM * 4 + 15));
         if ($urandom_range(0, 1) == 0)
            do_read(a, "rand_rd");
         else
            do_write(a, $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "rand_wr");
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      req.aw_addr = BASE + 4; req.aw_valid = 1'b1;
      step();
      req.aw_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < NUM; i++) m_regs[i] = 32'h0;
      @(negedge clk);
      n_vec++;
      if ({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid} !== 5'b11100) begin
         n_err++;
         $display("FAIL rstmid_ready: got %b expected 11100",
                  {resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid});
      end
      step();
      req.w_data = 32'hFEEDFACE; req.w_strb = 4'hF; req.w_valid = 1'b1;
      step();
      req.w_valid = 1'b0;
      seen = 0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         if (resp.b_valid !== 1'b0 || wr_pulse !== '0) seen++;
         step();
      end
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL rstmid_no_b: got %0d cycles with B/pulse expected 0", seen);
      end
      n_vec++;
      if (reg_o !== m_flat()) begin
         n_err++;
         $display("FAIL rstmid_regs: got %h expected %h", reg_o, m_flat());
      end
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      req = '0;
      req.b_ready = 1'b1;
      req.r_ready = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < NUM; i++) ro_data[i*32 +: 32] = $urandom;
      ro_data[3*32 +: 32] = 32'hCAFE0001;
      for (int i = 0; i < NUM; i++) m_regs[i] = 32'h0;

      test_reset();
      test_write_timing();
      test_strobe();
      test_read_only();
      test_out_of_range();
      test_read_during_commit();
      test_b_stall();
      test_random();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pl_axil_regbank
`default_nettype wire

// File: doc/pl_axil_regbank.md
PL_AXIL_REGBANK -- requirements
Module: pl_axil_regbank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of 32-bit registers, legal 2..64.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0: byte base address of the bank.
REQ-003 SHALL have parameter RO_MASK, default '0: NUM_REGS bits, bit i=1 makes register i read-only.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset; synchronous and active-high.
REQ-006 SHALL have port req_i, input, pl_m_axil_req_t: AXI-Lite requests from the peripheral-link xbar master port.
REQ-007 SHALL have port resp_o, output, pl_m_axil_resp_t: AXI-Lite responses to the xbar.
REQ-008 SHALL have port reg_o, output, NUM_REGS x 32: current writable-register contents.
REQ-009 SHALL have port ro_data_i, input, NUM_REGS x 32: hardware values returned for read-only registers.
REQ-010 SHALL have port wr_pulse_o, output, NUM_REGS: one-cycle pulse per register on write commit.

Function
REQ-011 SHALL compute index = (addr - BASE_ADDR) >> 2, ignoring addr[1:0]; in range iff addr >= BASE_ADDR and index < NUM_REGS.
REQ-012 SHALL accept AW and W independently: aw_ready = ~aw_held & ~b_valid, w_ready = ~w_held & ~b_valid.
REQ-013 SHALL latch addr/data/strb on handshake, set aw_held/w_held, and support either channel arriving first or both in the same cycle.
REQ-014 SHALL commit in the first cycle with aw_held & w_held & ~b_valid, clearing both held flags at that edge and setting b_valid.
REQ-015 SHALL let b_valid rise two cycles after the later AW/W handshake cycle, and hold b_valid and b.resp stable until b_ready.
REQ-016 SHALL on commit to an in-range writable register update each byte k with strb[k]=1, keep bytes with strb[k]=0, pulse wr_pulse_o[index], and respond OKAY (2'b00).
REQ-017 SHALL on commit to an out-of-range or read-only target leave all registers unchanged, pulse nothing, and respond SLVERR (2'b10).
REQ-018 SHALL give a commit with strb = 0 to a writable register OKAY with no data change, while still pulsing wr_pulse_o.
REQ-019 SHALL drive ar_ready = ~r_valid, allowing at most one outstanding read.
REQ-020 SHALL after AR handshake in cycle T drive r_valid with registered r.data/r.resp in cycle T+1, held stable until r_ready.
REQ-021 SHALL return reg_o[index] for writable in-range reads, ro_data_i[index] sampled in cycle T for read-only reads, and 32'h0 with SLVERR for out-of-range reads.
REQ-022 SHALL return the pre-write value when a read and a write commit to the same register fall in the same cycle.
REQ-023 SHALL keep the read and write paths independent, so a stalled b_ready never blocks reads and vice versa.

Reset
REQ-024 SHALL while rst_i=1 at an edge clear all registers, held flags, b_valid, r_valid and wr_pulse_o to 0.
REQ-025 SHALL drive aw_ready/w_ready/ar_ready = 1 after reset.
REQ-026 SHALL on reset mid-transaction discard pending AW/W/AR state with no response issued and no register update.

Structure
REQ-027 SHALL take pl_m_axil_req_t/resp_t and PL_MP_DW/PL_MP_AW from hyper_titan_nocs_pkg.
REQ-028 SHALL add constants PL_RESP_OKAY = 2'b00 and PL_RESP_SLVERR = 2'b10 to hyper_titan_nocs_pkg.
REQ-029 SHALL be implemented as a flat module with no sub-modules; decode is a local function shared by the read and write paths.

Verification
REQ-030 SHALL verify: AW addr=BASE+8 in cycle 0, W data=32'hDEADBEEF strb=4'hF in cycle 3 -> b_valid in cycle 5 with OKAY, reg_o[2]=DEADBEEF, wr_pulse_o[2] for one cycle.
REQ-031 SHALL verify: write 32'h11223344 then strb=4'b0101 data 32'hAABBCCDD to reg 1 -> reg_o[1]=32'h11BB33DD.
REQ-032 SHALL verify: RO_MASK bit 3 set, ro_data_i[3]=32'hCAFE0001, write to reg 3 -> SLVERR with reg unchanged; read reg 3 -> 32'hCAFE0001 OKAY.
REQ-033 SHALL verify: read at BASE+4*NUM_REGS -> r.data=0 with SLVERR; write there -> SLVERR and no wr_pulse_o.
REQ-034 SHALL verify: b_ready held 0 for 10 cycles -> aw_ready=w_ready=0 throughout, reads to reg 0 still complete each in 1 cycle, B is stable.
REQ-035 SHALL verify: rst_i asserted with aw_held=1 and w not yet received -> no B issued afterwards, and all ready signals are 1 the cycle after reset.
